// File: rtl/zing_record_fifo_pkg.sv
// Shared s_ing/z_ing record definitions and the s_ing -> z_ing op transform.
package test_package;

  localparam int unsigned NUM = 6;
  localparam int unsigned OPW = 32;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [NUM-1:0] pl;
  } s_ing;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [NUM-1:0] pl;
  } z_ing;

  function automatic z_ing to_zing(input s_ing s);
    z_ing z;
    z.op    = s.op;
    z.op[9] = 1'b0;
    z.pl    = s.pl;
    return z;
  endfunction

endpackage

// File: rtl/zing_record_fifo_mem.sv
// Record storage for zing_record_fifo: entry array plus write/read pointers.
module zing_fifo_mem
  import test_package::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clock,
  input  logic rst,
  input  logic wr_en,
  input  z_ing wr_data,
  input  logic rd_adv,
  output z_ing head
);

  localparam int unsigned AW = $clog2(DEPTH);

  z_ing          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Entries are cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '{default: '0};
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_adv) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/zing_record_fifo.sv
// s_ing -> z_ing record FIFO: clears op bit 9, drops all-zero pl records.
// Optional ZING_RECORD_FIFO_STATS_EN adds saturating acc_cnt/drop_cnt ports.
module zing_record_fifo
  import test_package::*;
#(
  parameter int unsigned NUM   = 6,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned OPW   = 32
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic [OPW-1:0]             s_op,
  input  logic [NUM-1:0]             s_pl,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [OPW-1:0]             z_op,
  output logic [NUM-1:0]             z_pl,
  output logic                       z_valid,
  input  logic                       z_ready,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       drop_pulse
`ifdef ZING_RECORD_FIFO_STATS_EN
  ,
  output logic [31:0]                acc_cnt,
  output logic [15:0]                drop_cnt
`endif
);

  localparam int unsigned FW = $clog2(DEPTH+1);

  s_ing in_rec;
  z_ing head;
  logic accept;
  logic is_drop;
  logic push;
  logic pop;

  assign in_rec  = '{op: s_op, pl: s_pl};

  // Readiness comes from registered fill only; a pop at full does not open it.
  assign s_ready = !rst && (fill < FW'(DEPTH));
  assign accept  = s_valid && s_ready;
  assign is_drop = accept && (s_pl == '0);
  assign push    = accept && (s_pl != '0);
  assign z_valid = (fill != '0);
  assign pop     = z_valid && z_ready;

  always_ff @(posedge clock) begin
    if (rst) begin
      fill       <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= is_drop;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  zing_fifo_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clock  (clock),
    .rst    (rst),
    .wr_en  (push),
    .wr_data(to_zing(in_rec)),
    .rd_adv (pop),
    .head   (head)
  );

  assign z_op = head.op;
  assign z_pl = head.pl;

`ifdef ZING_RECORD_FIFO_STATS_EN
  always_ff @(posedge clock) begin
    if (rst) begin
      acc_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (push && (acc_cnt != '1)) begin
        acc_cnt <= acc_cnt + 1'b1;
      end
      if (is_drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_zing_record_fifo.sv
// Testbench for zing_record_fifo: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_zing_record_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned FW    = $clog2(DEPTH+1);

  logic          clock = 1'b0;
  logic          rst   = 1'b1;
  logic [31:0]   s_op  = '0;
  logic [5:0]    s_pl  = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [31:0]   z_op;
  logic [5:0]    z_pl;
  logic          z_valid;
  logic          z_ready = 1'b0;
  logic [FW-1:0] fill;
  logic          drop_pulse;
`ifdef ZING_RECORD_FIFO_STATS_EN
  logic [31:0]   acc_cnt;
  logic [15:0]   drop_cnt;
  logic [31:0]   m_acc  = '0;
  logic [15:0]   m_dcnt = '0;
`endif

  always #5 clock = ~clock;

  zing_record_fifo #(
    .NUM  (6),
    .DEPTH(DEPTH),
    .OPW  (32)
  ) dut (
    .clock     (clock),
    .rst       (rst),
    .s_op      (s_op),
    .s_pl      (s_pl),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .z_op      (z_op),
    .z_pl      (z_pl),
    .z_valid   (z_valid),
    .z_ready   (z_ready),
    .fill      (fill),
    .drop_pulse(drop_pulse)
`ifdef ZING_RECORD_FIFO_STATS_EN
    ,
    .acc_cnt   (acc_cnt),
    .drop_cnt  (drop_cnt)
`endif
  );

  // Upstream must hold a stalled record unchanged until it is taken.
  assert property (@(posedge clock) disable iff (rst)
    (s_valid && !s_ready) |=> (s_valid && $stable(s_op) && $stable(s_pl)))
    else $error("FAIL upstream_hold: s_valid/s_op/s_pl changed while stalled");

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic sv, input logic [31:0] op,
                       input logic [5:0] pl, input logic zr);
    rst     = r;
    s_valid = sv;
    s_op    = op;
    s_pl    = pl;
    z_ready = zr;
  endtask

  // Reference model: an ordered list of stored records plus the pending drop flag.
  typedef struct {
    logic [31:0] op;
    logic [5:0]  pl;
  } rec_t;

  rec_t q[$];
  logic m_drop = 1'b0;

  task automatic mcycle(input logic r, input logic sv, input logic [31:0] op,
                        input logic [5:0] pl, input logic zr);
    logic er;
    logic acc;
    logic pop;
    rec_t nr;
    drive(r, sv, op, pl, zr);
    #1;
    er = !r && (q.size() < int'(DEPTH));
    check("s_ready", 64'(s_ready), 64'(er));
    check("fill", 64'(fill), 64'(q.size()));
    check("z_valid", 64'(z_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check("z_op", 64'(z_op), 64'(q[0].op));
      check("z_pl", 64'(z_pl), 64'(q[0].pl));
    end
    check("drop_pulse", 64'(drop_pulse), 64'(m_drop));
`ifdef ZING_RECORD_FIFO_STATS_EN
    check("acc_cnt", 64'(acc_cnt), 64'(m_acc));
    check("drop_cnt", 64'(drop_cnt), 64'(m_dcnt));
`endif
    if (r) begin
      q.delete();
      m_drop = 1'b0;
`ifdef ZING_RECORD_FIFO_STATS_EN
      m_acc  = '0;
      m_dcnt = '0;
`endif
    end else begin
      acc    = sv && er;
      pop    = (q.size() != 0) && zr;
      m_drop = acc && (pl == 6'd0);
      if (pop) void'(q.pop_front());
      if (acc && (pl != 6'd0)) begin
        nr.op = op & ~32'h0000_0200;
        nr.pl = pl;
        q.push_back(nr);
      end
`ifdef ZING_RECORD_FIFO_STATS_EN
      if (acc && (pl != 6'd0) && (m_acc != '1)) m_acc = m_acc + 1;
      if (m_drop && (m_dcnt != '1)) m_dcnt = m_dcnt + 1;
`endif
    end
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic          sv;
    logic [31:0]   op;
    logic [5:0]    pl;
    logic          zr;
    logic          rdy;
    logic [FW-1:0] f;
    logic          zv;
    logic [31:0]   zop;
    logic [5:0]    zpl;
    logic          dp;
  } vec_t;

  vec_t tbl[14];

  task automatic reset_and_check();
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    @(posedge clock);
    #1;
    check("rst_ready", 64'(s_ready), 64'(1'b0));
    check("rst_fill", 64'(fill), 64'(0));
    check("rst_z_valid", 64'(z_valid), 64'(1'b0));
    check("rst_z_op", 64'(z_op), 64'(32'h0));
    check("rst_z_pl", 64'(z_pl), 64'(6'h0));
    check("rst_drop", 64'(drop_pulse), 64'(1'b0));
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    #1;
    check("post_rst_ready", 64'(s_ready), 64'(1'b1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        pend;
    logic        r;
    logic        sv;
    logic        zr;
    logic [31:0] op;
    logic [5:0]  pl;

    //            sv  op            pl     zr  rdy f  zv  zop           zpl    dp
    tbl[0]  = '{1'b1, 32'hFFFF_FFFF, 6'h05, 1'b0, 1'b1, 1, 1'b1, 32'hFFFF_FDFF, 6'h05, 1'b0};
    tbl[1]  = '{1'b1, 32'h0000_0200, 6'h00, 1'b0, 1'b1, 1, 1'b1, 32'hFFFF_FDFF, 6'h05, 1'b1};
    tbl[2]  = '{1'b1, 32'h1234_5678, 6'h02, 1'b1, 1'b1, 1, 1'b1, 32'h1234_5478, 6'h02, 1'b0};
    tbl[3]  = '{1'b1, 32'hAAAA_AAAA, 6'h3F, 1'b0, 1'b1, 2, 1'b1, 32'h1234_5478, 6'h02, 1'b0};
    tbl[4]  = '{1'b1, 32'h0000_0000, 6'h00, 1'b1, 1'b1, 1, 1'b1, 32'hAAAA_A8AA, 6'h3F, 1'b1};
    tbl[5]  = '{1'b0, 32'h0000_0000, 6'h00, 1'b1, 1'b1, 0, 1'b0, 32'h0,         6'h00, 1'b0};
    tbl[6]  = '{1'b0, 32'h0000_0000, 6'h00, 1'b1, 1'b1, 0, 1'b0, 32'h0,         6'h00, 1'b0};
    tbl[7]  = '{1'b1, 32'h0000_0301, 6'h01, 1'b0, 1'b1, 1, 1'b1, 32'h0000_0101, 6'h01, 1'b0};
    tbl[8]  = '{1'b1, 32'h0000_0302, 6'h02, 1'b0, 1'b1, 2, 1'b1, 32'h0000_0101, 6'h01, 1'b0};
    tbl[9]  = '{1'b1, 32'h0000_0303, 6'h03, 1'b0, 1'b1, 3, 1'b1, 32'h0000_0101, 6'h01, 1'b0};
    tbl[10] = '{1'b1, 32'h0000_0304, 6'h04, 1'b0, 1'b1, 4, 1'b1, 32'h0000_0101, 6'h01, 1'b0};
    tbl[11] = '{1'b1, 32'h0000_0305, 6'h05, 1'b0, 1'b0, 4, 1'b1, 32'h0000_0101, 6'h01, 1'b0};
    tbl[12] = '{1'b1, 32'h0000_0305, 6'h05, 1'b1, 1'b0, 3, 1'b1, 32'h0000_0102, 6'h02, 1'b0};
    tbl[13] = '{1'b1, 32'h0000_0305, 6'h05, 1'b0, 1'b1, 4, 1'b1, 32'h0000_0102, 6'h02, 1'b0};

    @(posedge clock);
    reset_and_check();

    for (int i = 0; i < 14; i++) begin
      drive(1'b0, tbl[i].sv, tbl[i].op, tbl[i].pl, tbl[i].zr);
      #1;
      check($sformatf("tbl%0d_ready", i), 64'(s_ready), 64'(tbl[i].rdy));
      @(posedge clock);
      #1;
      check($sformatf("tbl%0d_fill", i), 64'(fill), 64'(tbl[i].f));
      check($sformatf("tbl%0d_z_valid", i), 64'(z_valid), 64'(tbl[i].zv));
      if (tbl[i].zv) begin
        check($sformatf("tbl%0d_z_op", i), 64'(z_op), 64'(tbl[i].zop));
        check($sformatf("tbl%0d_z_pl", i), 64'(z_pl), 64'(tbl[i].zpl));
      end
      check($sformatf("tbl%0d_drop", i), 64'(drop_pulse), 64'(tbl[i].dp));
    end

    // Drain the full FIFO: the held fifth record sits behind 2, 3, 4.
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      #1;
      check($sformatf("drain%0d_z_pl", k), 64'(z_pl), 64'(6'(k + 2)));
      check($sformatf("drain%0d_z_op", k), 64'(z_op), 64'(32'h102 + 32'(k)));
      @(posedge clock);
      #1;
    end
    check("drain_fill", 64'(fill), 64'(0));
    check("drain_z_valid", 64'(z_valid), 64'(1'b0));

    reset_and_check();

    // Reset with three records buffered, then single-cycle latency afterwards.
    mcycle(1'b0, 1'b1, 32'hC000_0201, 6'h11, 1'b0);
    mcycle(1'b0, 1'b1, 32'hC000_0202, 6'h12, 1'b0);
    mcycle(1'b0, 1'b1, 32'hC000_0203, 6'h13, 1'b0);
    mcycle(1'b1, 1'b1, 32'hC000_0204, 6'h14, 1'b0);
    mcycle(1'b0, 1'b0, 32'h0, 6'h00, 1'b0);
    check("midrst_z_op", 64'(z_op), 64'(32'h0));
    check("midrst_z_pl", 64'(z_pl), 64'(6'h0));
    mcycle(1'b0, 1'b1, 32'h0000_0777, 6'h07, 1'b0);
    check("latency_z_valid", 64'(z_valid), 64'(1'b1));
    check("latency_z_pl", 64'(z_pl), 64'(6'h07));

    // Continuous stream at fill=1 across several pointer wraps.
    for (int k = 0; k < 10; k++) begin
      mcycle(1'b0, 1'b1, 32'h5000_0200 + 32'(k), 6'(k + 1), 1'b1);
    end
    check("stream_fill", 64'(fill), 64'(1));

`ifdef ZING_RECORD_FIFO_STATS_EN
    mcycle(1'b1, 1'b0, '0, '0, 1'b0);
    mcycle(1'b0, 1'b1, 32'h11, 6'h01, 1'b1);
    mcycle(1'b0, 1'b1, 32'h12, 6'h00, 1'b1);
    mcycle(1'b0, 1'b1, 32'h13, 6'h02, 1'b1);
    mcycle(1'b0, 1'b1, 32'h14, 6'h00, 1'b1);
    mcycle(1'b0, 1'b1, 32'h15, 6'h03, 1'b1);
    mcycle(1'b0, 1'b0, '0, '0, 1'b1);
    check("stats_acc_3", 64'(acc_cnt), 64'(32'd3));
    check("stats_drop_2", 64'(drop_cnt), 64'(16'd2));
    force dut.acc_cnt  = 32'hFFFF_FFFE;
    force dut.drop_cnt = 16'hFFFE;
    #1;
    release dut.acc_cnt;
    release dut.drop_cnt;
    m_acc  = 32'hFFFF_FFFE;
    m_dcnt = 16'hFFFE;
    mcycle(1'b0, 1'b1, 32'h21, 6'h01, 1'b1);
    mcycle(1'b0, 1'b1, 32'h22, 6'h00, 1'b1);
    mcycle(1'b0, 1'b1, 32'h23, 6'h02, 1'b1);
    mcycle(1'b0, 1'b1, 32'h24, 6'h00, 1'b1);
    mcycle(1'b0, 1'b1, 32'h25, 6'h03, 1'b1);
    mcycle(1'b0, 1'b0, '0, '0, 1'b1);
    check("stats_acc_sat", 64'(acc_cnt), 64'(32'hFFFF_FFFF));
    check("stats_drop_sat", 64'(drop_cnt), 64'(16'hFFFF));
`endif

    // Randomized traffic; downstream readiness alternates phases to reach full and empty.
    pend = 1'b0;
    sv   = 1'b0;
    op   = '0;
    pl   = '0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      if (!pend) begin
        sv = ($urandom_range(0, 3) != 0);
        op = $urandom;
        pl = ($urandom_range(0, 3) == 0) ? 6'h00 : 6'($urandom_range(1, 63));
      end
      if (((i / 200) % 2) == 0) zr = ($urandom_range(0, 3) == 0);
      else                      zr = ($urandom_range(0, 3) != 0);
      pend = !r && sv && !(q.size() < int'(DEPTH));
      mcycle(r, sv, op, pl, zr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
